// File: rtl/vertex_hex_pipe.sv
// vertex_hex_pipe: 4-stage affine transform to screen space, cube-hex rounding and LOD select.
// Valid/ready handshake with a single global advance; tag rides alongside each vertex.
module vertex_hex_pipe #(
   parameter int W = 32,
   parameter int FRAC = 16,
   parameter int TAG_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            in_x,
   input  logic [W-1:0]            in_y,
   input  logic [W-1:0]            in_z,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic [0:1][0:3][W-1:0]  matrix,
   input  logic [W-1:0]            inv_hex_size,
   input  logic [2*W-1:0]          lod_near,
   input  logic [2*W-1:0]          lod_far,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [W-1:0]            screen_x,
   output logic [W-1:0]            screen_y,
   output logic [W-1:0]            hex_q,
   output logic [W-1:0]            hex_r,
   output logic [W-1:0]            hex_s,
   output logic [1:0]              hex_lod,
   output logic [TAG_W-1:0]        out_tag
);
   localparam int W2 = 2 * W;
   localparam logic signed [W-1:0] KS  = W'((64'd57735 * (64'd1 << FRAC) + 64'd50000) / 64'd100000);
   localparam logic signed [W-1:0] K13 = W'(((64'd1 << FRAC) + 64'd1) / 64'd3);
   localparam logic signed [W-1:0] K23 = W'(((64'd2 << FRAC) + 64'd1) / 64'd3);
   localparam logic signed [W2+1:0] HI = {{(W2-W+3){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [W2+1:0] LO = {{(W2-W+3){1'b1}}, {(W-1){1'b0}}};
   localparam logic signed [W+1:0] HALF = (W+2)'(1) <<< (FRAC - 1);

   function automatic logic signed [W2-1:0] mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      return W2'(a) * W2'(b);
   endfunction

   function automatic logic signed [W2+1:0] ext(input logic [W2-1:0] a);
      return {{2{a[W2-1]}}, a};
   endfunction

   function automatic logic [W-1:0] sat(input logic signed [W2+1:0] v);
      return v > HI ? HI[W-1:0] : v < LO ? LO[W-1:0] : v[W-1:0];
   endfunction

   function automatic logic signed [W+1:0] absd(input logic signed [W+1:0] v);
      return v < 0 ? -v : v;
   endfunction

   logic [3:0]              v;
   logic [0:7][W2-1:0]      pc, p1;
   logic [TAG_W-1:0]        t1, t2, t3;
   logic [W-1:0]            sx2, sy2, sx3, sy3, qf3, rf3;
   logic [W:0]              sf3, sf_c;
   logic [W2-1:0]           dist3;
   logic signed [W2+1:0]    sum0, sum1, a_c;
   logic [W-1:0]            qt_c, qf_c, rt_c, rf_c;
   logic [W2:0]             d2_c;
   logic signed [W+1:0]     qe, re, se, qi, ri, si, dq, dr, ds;
   logic                    qsel, rsel;
   logic [W-1:0]            qo, ro, so;

   assign out_valid = v[3];
   assign in_ready  = out_ready | ~v[3];

   // translation column is promoted to the product scale so all eight terms add directly
   always_comb begin
      pc = '0;
      for (int i = 0; i < 2; i++) begin
         pc[4*i]   = mul(matrix[i][0], in_x);
         pc[4*i+1] = mul(matrix[i][1], in_y);
         pc[4*i+2] = mul(matrix[i][2], in_z);
         pc[4*i+3] = {{(W2-W){matrix[i][3][W-1]}}, matrix[i][3]} << FRAC;
      end
   end

   assign sum0 = ext(p1[0]) + ext(p1[1]) + ext(p1[2]) + ext(p1[3]);
   assign sum1 = ext(p1[4]) + ext(p1[5]) + ext(p1[6]) + ext(p1[7]);

   assign a_c  = ext(mul(KS, sx2)) - ext(mul(K13, sy2));
   assign qt_c = sat(a_c >>> FRAC);
   assign qf_c = sat(ext(mul(qt_c, inv_hex_size)) >>> FRAC);
   assign rt_c = sat(ext(mul(K23, sy2)) >>> FRAC);
   assign rf_c = sat(ext(mul(rt_c, inv_hex_size)) >>> FRAC);
   assign sf_c = -{qf_c[W-1], qf_c} - {rf_c[W-1], rf_c};
   assign d2_c = {1'b0, mul(sx2, sx2)} + {1'b0, mul(sy2, sy2)};

   // the component farthest from its rounded value is rebuilt from the other two
   always_comb begin
      qe   = $signed({{2{qf3[W-1]}}, qf3});
      re   = $signed({{2{rf3[W-1]}}, rf3});
      se   = $signed({sf3[W], sf3});
      qi   = (qe + HALF) >>> FRAC;
      ri   = (re + HALF) >>> FRAC;
      si   = (se + HALF) >>> FRAC;
      dq   = absd((qi <<< FRAC) - qe);
      dr   = absd((ri <<< FRAC) - re);
      ds   = absd((si <<< FRAC) - se);
      qsel = dq > dr && dq > ds;
      rsel = !qsel && dr > ds;
      qo   = W'(qsel ? -ri - si : qi);
      ro   = W'(rsel ? -qi - si : ri);
      so   = W'(qsel || rsel ? si : -qi - ri);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v        <= '0;
         p1       <= '0;
         t1       <= '0;
         sx2      <= '0;
         sy2      <= '0;
         t2       <= '0;
         sx3      <= '0;
         sy3      <= '0;
         qf3      <= '0;
         rf3      <= '0;
         sf3      <= '0;
         dist3    <= '0;
         t3       <= '0;
         screen_x <= '0;
         screen_y <= '0;
         hex_q    <= '0;
         hex_r    <= '0;
         hex_s    <= '0;
         hex_lod  <= '0;
         out_tag  <= '0;
      end else if (in_ready) begin
         v        <= {v[2:0], in_valid};
         p1       <= pc;
         t1       <= in_tag;
         sx2      <= sat(sum0 >>> FRAC);
         sy2      <= sat(sum1 >>> FRAC);
         t2       <= t1;
         sx3      <= sx2;
         sy3      <= sy2;
         qf3      <= qf_c;
         rf3      <= rf_c;
         sf3      <= sf_c;
         dist3    <= d2_c[W2] ? '1 : d2_c[W2-1:0];
         t3       <= t2;
         screen_x <= sx3;
         screen_y <= sy3;
         hex_q    <= qo;
         hex_r    <= ro;
         hex_s    <= so;
         hex_lod  <= dist3 > lod_far ? 2'd3 : dist3 > lod_near ? 2'd2 : 2'd1;
         out_tag  <= t3;
      end
   end
endmodule

// File: tb/tb_vertex_hex_pipe.sv
// tb_vertex_hex_pipe: directed and randomized checks of vertex_hex_pipe against a wide-integer reference model.
module tb_vertex_hex_pipe;
   localparam int W = 32, FRAC = 16, TAG_W = 8;
   typedef logic signed [127:0] big_t;
   typedef struct packed {
      logic [W-1:0] sx, sy, q, r, s;
      logic [1:0] lod;
      logic [TAG_W-1:0] tag;
   } res_t;
   localparam big_t HI = 128'sd2147483647;
   localparam big_t LO = -128'sd2147483648;

   logic clk = 0;
   logic reset, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] in_x, in_y, in_z, inv_hex_size, screen_x, screen_y, hex_q, hex_r, hex_s;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [0:1][0:3][W-1:0] matrix;
   logic [2*W-1:0] lod_near, lod_far;
   logic [1:0] hex_lod;
   int checks = 0, failures = 0;
   res_t expq[$];

   vertex_hex_pipe #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
      .matrix(matrix), .inv_hex_size(inv_hex_size), .lod_near(lod_near), .lod_far(lod_far),
      .out_valid(out_valid), .out_ready(out_ready), .screen_x(screen_x), .screen_y(screen_y),
      .hex_q(hex_q), .hex_r(hex_r), .hex_s(hex_s), .hex_lod(hex_lod), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic big_t sgn(input logic [W-1:0] a);
      big_t r;
      r = $signed(a);
      return r;
   endfunction

   function automatic big_t satw(input big_t v);
      return v > HI ? HI : v < LO ? LO : v;
   endfunction

   // floor(v / 2^FRAC) by plain division, corrected toward -inf
   function automatic big_t fdiv(input big_t v);
      big_t q;
      q = v / 65536;
      if (v < 0 && q * 65536 != v) q = q - 1;
      return q;
   endfunction

   function automatic res_t model(input logic [W-1:0] x, y, z, input logic [TAG_W-1:0] tag);
      big_t pos[2];
      big_t qf, rf, sf, qi, ri, si, dq, dr, ds, d2, nn, nf;
      res_t r;
      for (int i = 0; i < 2; i++)
         pos[i] = satw(fdiv(sgn(matrix[i][0]) * sgn(x) + sgn(matrix[i][1]) * sgn(y)
                          + sgn(matrix[i][2]) * sgn(z) + sgn(matrix[i][3]) * 65536));
      qf = satw(fdiv(satw(fdiv(37837 * pos[0] - 21845 * pos[1])) * sgn(inv_hex_size)));
      rf = satw(fdiv(satw(fdiv(43691 * pos[1])) * sgn(inv_hex_size)));
      sf = -qf - rf;
      qi = fdiv(qf + 32768);
      ri = fdiv(rf + 32768);
      si = fdiv(sf + 32768);
      dq = qi * 65536 - qf;
      dr = ri * 65536 - rf;
      ds = si * 65536 - sf;
      if (dq < 0) dq = -dq;
      if (dr < 0) dr = -dr;
      if (ds < 0) ds = -ds;
      if (dq > dr && dq > ds) qi = -ri - si;
      else if (dr > ds) ri = -qi - si;
      else si = -qi - ri;
      d2 = pos[0] * pos[0] + pos[1] * pos[1];
      nn = lod_near;
      nf = lod_far;
      r.sx = pos[0][W-1:0];
      r.sy = pos[1][W-1:0];
      r.q = qi[W-1:0];
      r.r = ri[W-1:0];
      r.s = si[W-1:0];
      r.lod = d2 > nf ? 2'd3 : d2 > nn ? 2'd2 : 2'd1;
      r.tag = tag;
      return r;
   endfunction

   function automatic logic [W-1:0] rnd(input int sh);
      logic signed [W-1:0] v;
      v = $urandom;
      return v >>> sh;
   endfunction

   task automatic check_out(input res_t e);
      logic [W-1:0] sum3;
      sum3 = hex_q + hex_r + hex_s;
      chk("screen_x", screen_x, e.sx);
      chk("screen_y", screen_y, e.sy);
      chk("hex_q", hex_q, e.q);
      chk("hex_r", hex_r, e.r);
      chk("hex_s", hex_s, e.s);
      chk("hex_lod", hex_lod, e.lod);
      chk("out_tag", out_tag, e.tag);
      chk("qrs_sum", sum3, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_one(input logic [W-1:0] x, y, z, input logic [TAG_W-1:0] tag);
      in_x = x;
      in_y = y;
      in_z = z;
      in_tag = tag;
      in_valid = 1;
      #1 chk("accept_ready", in_ready, 1);
      tick();
      in_valid = 0;
      for (int k = 1; k < 4; k++) begin
         chk("latency_early", out_valid, 0);
         tick();
      end
      chk("latency_valid", out_valid, 1);
      check_out(model(x, y, z, tag));
   endtask

   task automatic randomize_cfg(input int msh, input int tsh);
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 4; j++) matrix[i][j] = rnd(j == 3 ? tsh : msh);
      inv_hex_size = 32'h8000 + $urandom_range(0, 32'h20000);
      lod_near = 64'($urandom_range(0, 40000)) << 32;
      lod_far = 64'($urandom_range(0, 160000)) << 32;
   endtask

   // rnd_ready=0: fixed stall window on cycles 3..12; rnd_ready=1: random valid/ready
   task automatic stream(input int n, input int base, input bit rnd_ready, input int csh);
      logic [W-1:0] xs[64], ys[64], zs[64];
      int sent = 0, got = 0, c = 0;
      bit acc;
      for (int i = 0; i < n; i++) begin
         xs[i] = rnd(csh);
         ys[i] = rnd(csh);
         zs[i] = rnd(csh);
      end
      expq.delete();
      while (got < n && c < 2000) begin
         if (!in_valid) in_valid = sent < n && (!rnd_ready || $urandom_range(3) != 0);
         if (sent < n) begin
            in_x = xs[sent];
            in_y = ys[sent];
            in_z = zs[sent];
            in_tag = TAG_W'(base + sent);
         end
         out_ready = rnd_ready ? $urandom_range(2) != 0 : !(c >= 3 && c <= 12);
         @(negedge clk);
         if (!rnd_ready && c >= 4 && c <= 12) chk("stall_in_ready", in_ready, 0);
         if (out_valid) begin
            checks++;
            assert (expq.size() != 0) else begin
               failures++;
               $error("FAIL unexpected_output got_tag=%0h exp=none", out_tag);
            end
            if (expq.size() != 0) begin
               check_out(expq[0]);
               if (out_ready) begin
                  void'(expq.pop_front());
                  got++;
               end
            end
         end
         acc = in_valid && in_ready;
         if (acc) begin
            expq.push_back(model(in_x, in_y, in_z, in_tag));
            sent++;
         end
         tick();
         if (acc) in_valid = 0;
         c++;
      end
      in_valid = 0;
      out_ready = 1;
      chk("stream_count", got, n);
   endtask

   initial begin
      reset = 1;
      in_valid = 0;
      out_ready = 1;
      in_x = 0;
      in_y = 0;
      in_z = 0;
      in_tag = 0;
      matrix = '0;
      matrix[0][0] = 32'h0001_0000;
      matrix[1][1] = 32'h0001_0000;
      inv_hex_size = 32'h0001_0000;
      lod_near = 64'h1_0000_0000;
      lod_far = 64'd100 << 32;
      idle(2);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_screen_x", screen_x, 0);
      chk("rst_hex_q", hex_q, 0);
      chk("rst_hex_lod", hex_lod, 0);
      chk("rst_out_tag", out_tag, 0);
      reset = 0;
      tick();

      send_one(0, 0, 0, 8'h11);
      chk("t1_screen_x", screen_x, 0);
      chk("t1_screen_y", screen_y, 0);
      chk("t1_hex_q", hex_q, 0);
      chk("t1_hex_r", hex_r, 0);
      chk("t1_hex_s", hex_s, 0);
      chk("t1_lod", hex_lod, 1);
      chk("t1_tag", out_tag, 8'h11);

      send_one(0, 32'h0003_0000, 0, 8'h22);
      chk("t2_screen_y", screen_y, 32'h0003_0000);
      chk("t2_hex_q", hex_q, 32'hFFFF_FFFF);
      chk("t2_hex_r", hex_r, 32'h0000_0002);
      chk("t2_hex_s", hex_s, 32'hFFFF_FFFF);
      chk("t2_lod", hex_lod, 2);

      idle(1);
      matrix[0][0] = 32'h7FFF_0000;
      lod_near = 0;
      lod_far = 64'h1_0000_0000;
      send_one(32'h0002_0000, 0, 0, 8'h33);
      chk("t3_sat_pos", screen_x, 32'h7FFF_FFFF);
      chk("t3_lod_pos", hex_lod, 3);
      idle(1);
      send_one(32'hFFFE_0000, 0, 0, 8'h34);
      chk("t3_sat_neg", screen_x, 32'h8000_0000);
      chk("t3_lod_neg", hex_lod, 3);

      idle(1);
      matrix[0][0] = 32'h0001_0000;
      lod_near = 64'h1_0000_0000;
      lod_far = 64'h1_0000_0000;
      send_one(32'h0001_0000, 0, 0, 8'h66);
      chk("t6_lod_equal", hex_lod, 1);
      idle(1);
      lod_near = 64'hFFFF_FFFF;
      send_one(32'h0001_0000, 0, 0, 8'h67);
      chk("t6_lod_near", hex_lod, 2);

      idle(4);
      randomize_cfg(13, 8);
      stream(10, 0, 0, 10);

      idle(4);
      in_valid = 1;
      for (int k = 0; k < 4; k++) begin
         in_x = rnd(10);
         in_y = rnd(10);
         in_tag = TAG_W'(8'h40 + k);
         tick();
      end
      in_valid = 0;
      chk("t5_full", out_valid, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_screen_x", screen_x, 0);
      chk("t5_screen_y", screen_y, 0);
      chk("t5_hex_q", hex_q, 0);
      chk("t5_hex_r", hex_r, 0);
      chk("t5_hex_s", hex_s, 0);
      chk("t5_hex_lod", hex_lod, 0);
      chk("t5_out_tag", out_tag, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t5_flushed", out_valid, 0);
      end
      send_one(rnd(10), rnd(10), rnd(10), 8'h55);

      idle(4);
      randomize_cfg(13, 8);
      stream(40, 100, 1, 10);
      idle(4);
      randomize_cfg(0, 0);
      stream(30, 200, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
